// File: rtl/dds_pkg.sv
// Shared definitions for the polyphonic DDS engine: waveform select codes
// and the offset-binary midscale helper.
package dds_pkg;

    typedef enum logic [2:0] {
        WAVE_SAW    = 3'd0,
        WAVE_SQUARE = 3'd1,
        WAVE_TRI    = 3'd2,
        WAVE_SINE   = 3'd3
    } wave_sel_e;

    function automatic int midscale(input int out_w);
        return 1 << (out_w - 1);
    endfunction

endpackage

// File: rtl/dds_wave_gen.sv
// Combinational waveform shaper: maps phase MSBs to an offset-binary sample.
// Define DDS_SINE_EN to build the quarter-wave sine LUT; otherwise sel 3 is triangle.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = 14,
    parameter int OUT_W   = 12
) (
    input  logic [2:0]         sel,
    input  logic [PHASE_W-1:0] p,
    output logic [OUT_W-1:0]   wave
);

    localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

    logic [OUT_W-1:0] saw_w;
    logic [OUT_W-1:0] square_w;
    logic [OUT_W-1:0] tri_w;
    logic [OUT_W-1:0] sine_w;

    assign saw_w    = p[PHASE_W-1 -: OUT_W];
    assign square_w = p[PHASE_W-1] ? '1 : '0;
    assign tri_w    = p[PHASE_W-1] ? ~p[PHASE_W-2 -: OUT_W] : p[PHASE_W-2 -: OUT_W];

`ifdef DDS_SINE_EN
    localparam int QW  = PHASE_W - 2;
    localparam int QN  = 1 << QW;
    localparam int AMP = (1 << (OUT_W - 1)) - 1;

    function automatic logic [OUT_W-1:0] quarter_sine(input int i);
        real x;
        x = real'(AMP) * $sin(3.14159265358979323846 * real'(i) / (2.0 * real'(QN)));
        return OUT_W'($rtoi(x + 0.5));
    endfunction

    logic [OUT_W-1:0] qlut [QN];
    logic [QW-1:0]    idx;
    logic [QW-1:0]    mirror;
    logic [OUT_W-1:0] mag;

    for (genvar gi = 0; gi < QN; gi++) begin : g_lut
        assign qlut[gi] = quarter_sine(gi);
    end

    assign idx    = p[QW-1:0];
    assign mirror = ~idx + QW'(1);

    // Odd quadrants read the table backwards; index 0 there is the peak,
    // which lies one past the end of the table.
    always_comb begin
        mag = qlut[idx];
        if (p[PHASE_W-2]) begin
            if (idx == '0) begin
                mag = OUT_W'(AMP);
            end else begin
                mag = qlut[mirror];
            end
        end
    end

    assign sine_w = p[PHASE_W-1] ? (MID - mag) : (MID + mag);
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, p};
    assign sine_w    = tri_w;
`endif

    always_comb begin
        wave = MID;
        case (sel)
            WAVE_SAW:    wave = saw_w;
            WAVE_SQUARE: wave = square_w;
            WAVE_TRI:    wave = tri_w;
            WAVE_SINE:   wave = sine_w;
            default:     wave = MID;
        endcase
    end

endmodule

// File: rtl/dds_poly_voice.sv
// Time-multiplexed polyphonic DDS: VOICES phase accumulators share one shaper
// and one mixer, one voice per slot. Optional sine via DDS_SINE_EN.
module dds_poly_voice
    import dds_pkg::*;
#(
    parameter int VOICES  = 4,
    parameter int TUNE_W  = 16,
    parameter int PHASE_W = 14,
    parameter int OUT_W   = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(VOICES)-1:0]  cfg_addr,
    input  logic [TUNE_W-1:0]          cfg_tune,
    input  logic [2:0]                 cfg_sel,
    input  logic                       cfg_en,
    input  logic                       cfg_phase_clr,
    output logic [OUT_W-1:0]           mix_out,
    output logic                       out_valid
);

    localparam int AW    = $clog2(VOICES);
    localparam int ACC_W = OUT_W + AW;
    localparam logic [OUT_W-1:0] MID       = OUT_W'(midscale(OUT_W));
    localparam logic [AW-1:0]    LAST_SLOT = AW'(VOICES - 1);

    logic [TUNE_W-1:0] phase_reg [VOICES];
    logic [TUNE_W-1:0] phase_next [VOICES];
    logic [TUNE_W-1:0] tune_reg [VOICES];
    logic [TUNE_W-1:0] tune_next [VOICES];
    logic [2:0]        sel_reg [VOICES];
    logic [2:0]        sel_next [VOICES];
    logic              en_reg [VOICES];
    logic              en_next [VOICES];

    logic [AW-1:0]     slot_reg;
    logic [OUT_W-1:0]  wave_reg;
    logic              wave_valid_reg;
    logic [AW-1:0]     wave_slot_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_sum;
    logic [OUT_W-1:0]  mix_reg;
    logic              out_valid_reg;
    logic [OUT_W-1:0]  shaped;

    // Register reads see pre-edge values, so a write landing in a voice's own
    // slot only affects the following frame; a phase clear beats the increment.
    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
        logic wr_hit;
        logic svc;

        assign wr_hit        = cfg_we && (cfg_addr == AW'(gi));
        assign svc           = (slot_reg == AW'(gi)) && en_reg[gi];
        assign tune_next[gi] = wr_hit ? cfg_tune : tune_reg[gi];
        assign sel_next[gi]  = wr_hit ? cfg_sel  : sel_reg[gi];
        assign en_next[gi]   = wr_hit ? cfg_en   : en_reg[gi];
        assign phase_next[gi] = (wr_hit && cfg_phase_clr) ? '0 :
                                svc ? (phase_reg[gi] + tune_reg[gi]) :
                                phase_reg[gi];
    end

    dds_wave_gen #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) u_shaper (
        .sel  (sel_reg[slot_reg]),
        .p    (phase_reg[slot_reg][TUNE_W-1 -: PHASE_W]),
        .wave (shaped)
    );

    assign acc_sum = acc_reg + ACC_W'(wave_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                phase_reg[i] <= '0;
                tune_reg[i]  <= '0;
                sel_reg[i]   <= '0;
                en_reg[i]    <= 1'b0;
            end
            slot_reg       <= '0;
            wave_reg       <= '0;
            wave_valid_reg <= 1'b0;
            wave_slot_reg  <= '0;
            acc_reg        <= '0;
            mix_reg        <= '0;
            out_valid_reg  <= 1'b0;
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                phase_reg[i] <= phase_next[i];
                tune_reg[i]  <= tune_next[i];
                sel_reg[i]   <= sel_next[i];
                en_reg[i]    <= en_next[i];
            end
            slot_reg       <= slot_reg + AW'(1);
            wave_reg       <= en_reg[slot_reg] ? shaped : MID;
            wave_valid_reg <= 1'b1;
            wave_slot_reg  <= slot_reg;
            out_valid_reg  <= 1'b0;
            // Stage 2 idles until stage 1 has produced a sample after reset.
            if (wave_valid_reg) begin
                acc_reg <= (wave_slot_reg == '0) ? ACC_W'(wave_reg) : acc_sum;
                if (wave_slot_reg == LAST_SLOT) begin
                    mix_reg       <= acc_sum[ACC_W-1:AW];
                    out_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign mix_out   = mix_reg;
    assign out_valid = out_valid_reg;

endmodule
